// File: rtl/alu_matrix_mac_sequencer.sv
// alu_matrix_mac_sequencer: sequential signed NxN matrix multiply C = A x B on one shared MAC.
// Runtime dimension, wrap/saturate result modes, start/busy/done handshake.
module alu_matrix_mac_sequencer #(
    parameter int N     = 5,
    parameter int W     = 8,
    parameter int ACC_W = 2*W+$clog2(N),
    parameter int DW    = $clog2(N+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [DW-1:0]    dim_i,
    input  logic             sat_en_i,
    input  logic [N*N*W-1:0] a_flat_i,
    input  logic [N*N*W-1:0] b_flat_i,
    output logic [N*N*W-1:0] c_flat_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_flag_o
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    // Packed [row][col][bit] matches the row-major flat bus layout exactly.
    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

    state_t                   state_q, state_d;
    mat_t                     a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DW-1:0]            d_q, d_d, i_q, i_d, j_q, j_d, k_q, k_d;
    logic                     sat_q, sat_d, ovf_q, ovf_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
    logic signed [2*W-1:0]    prod;
    logic [ACC_W-W:0]         sum_hi;
    logic [DW-1:0]            dim_eff;
    logic [W-1:0]             sat_val;
    logic                     accept, last_k, last_j, last_i, sum_ovf;

    assign accept  = (state_q == IDLE) && start_i;
    assign dim_eff = (dim_i == '0 || dim_i > DW'(N)) ? DW'(N) : dim_i;
    assign last_k  = k_q == d_q - DW'(1);
    assign last_j  = j_q == d_q - DW'(1);
    assign last_i  = i_q == d_q - DW'(1);
    assign prod    = $signed(a_q[i_q][k_q]) * $signed(b_q[k_q][j_q]);
    assign sum     = acc_q + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    // The sum fits in W signed bits only when every bit above the W-bit sign bit matches it.
    assign sum_hi  = sum[ACC_W-1:W-1];
    assign sum_ovf = !((&sum_hi) || !(|sum_hi));
    assign sat_val = sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (start_i ? MAC : IDLE)
                : state_q == MAC  ? ((last_k && last_j && last_i) ? DONE : MAC)
                : IDLE;
    end

    always_comb begin
        busy_o          = state_q == MAC;
        done_o          = state_q == DONE;
        c_flat_o        = c_q;
        overflow_flag_o = ovf_q;
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        d_d   = d_q;
        sat_d = sat_q;
        ovf_d = ovf_q;
        acc_d = acc_q;
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        if (accept) begin
            a_d   = a_flat_i;
            b_d   = b_flat_i;
            c_d   = '0;
            d_d   = dim_eff;
            sat_d = sat_en_i;
            ovf_d = 1'b0;
            acc_d = '0;
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
        end else if (state_q == MAC) begin
            k_d   = last_k ? '0 : k_q + DW'(1);
            j_d   = last_k ? (last_j ? '0 : j_q + DW'(1)) : j_q;
            i_d   = (last_k && last_j) ? (last_i ? '0 : i_q + DW'(1)) : i_q;
            acc_d = last_k ? '0 : sum;
            if (last_k) begin
                c_d[i_q][j_q] = (sum_ovf && sat_q) ? sat_val : sum[W-1:0];
                ovf_d         = ovf_q | sum_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            d_q   <= d_d;
            sat_q <= sat_d;
            ovf_q <= ovf_d;
            acc_q <= acc_d;
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
        end
    end
endmodule

// File: tb/tb_alu_matrix_mac_sequencer.sv
// tb_alu_matrix_mac_sequencer: directed vectors with hand-computed results for the matrix MAC sequencer.
module tb_alu_matrix_mac_sequencer;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int DW = $clog2(N+1);
    localparam int BW = N*N*W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sat_en = 1'b0;
    logic [DW-1:0] dim = '0;
    logic [BW-1:0] a = '0;
    logic [BW-1:0] b = '0;
    logic [BW-1:0] c;
    logic          busy, done, ovf;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    alu_matrix_mac_sequencer #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .dim_i(dim), .sat_en_i(sat_en),
        .a_flat_i(a), .b_flat_i(b), .c_flat_o(c), .busy_o(busy), .done_o(done),
        .overflow_flag_o(ovf)
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // d x d top-left block filled with v, the rest zero
    function automatic logic [BW-1:0] fill(input int d, input logic [W-1:0] v);
        logic [BW-1:0] m = '0;
        for (int r = 0; r < d; r++)
            for (int q = 0; q < d; q++) m[(r*N+q)*W +: W] = v;
        return m;
    endfunction

    function automatic logic [BW-1:0] ident();
        logic [BW-1:0] m = '0;
        for (int r = 0; r < N; r++) m[(r*N+r)*W +: W] = 8'd1;
        return m;
    endfunction

    // 1..25 row-major, optionally keeping only the d x d top-left block
    function automatic logic [BW-1:0] seq(input int d);
        logic [BW-1:0] m = '0;
        for (int r = 0; r < d; r++)
            for (int q = 0; q < d; q++) m[(r*N+q)*W +: W] = W'(r*N+q+1);
        return m;
    endfunction

    task automatic wait_done(input int exp_cyc, input bit pulse, input string tag);
        int cyc = 1;
        int bc  = 0;
        while (!done && cyc < 200) begin
            bc += int'(busy);
            start = pulse && (cyc % 7 == 3);
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, BW'(cyc), BW'(exp_cyc));
        check({tag, " busy_cycles"}, BW'(bc), BW'(exp_cyc - 1));
        check({tag, " busy_at_done"}, BW'(busy), '0);
    endtask

    task automatic run(input logic [DW-1:0] dm, input logic se, input logic [BW-1:0] av,
                       input logic [BW-1:0] bv, input int exp_cyc, input bit pulse, input string tag);
        dim = dm; sat_en = se; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        dim = dm + DW'(1); sat_en = ~se; a = ~av; b = ~bv;
        check({tag, " c_cleared"}, c, '0);
        check({tag, " ovf_cleared"}, BW'(ovf), '0);
        wait_done(exp_cyc, pulse, tag);
    endtask

    initial begin
        #1;
        check("reset c", c, '0);
        check("reset busy", BW'(busy), '0);
        check("reset done", BW'(done), '0);
        check("reset ovf", BW'(ovf), '0);
        #7 rst_n = 1'b1;
        tick();

        run(3'd5, 1'b0, ident(), seq(5), 126, 1'b0, "ident5");
        check("ident5 c", c, seq(5));
        check("ident5 ovf", BW'(ovf), '0);
        tick();

        run(3'd3, 1'b0, fill(5, 8'hFF), fill(5, 8'h02), 28, 1'b0, "neg3");
        check("neg3 c", c, fill(3, 8'hFA));
        tick();

        run(3'd2, 1'b1, fill(5, 8'h64), fill(5, 8'h64), 9, 1'b0, "sat2");
        check("sat2 c", c, fill(2, 8'h7F));
        check("sat2 ovf", BW'(ovf), BW'(1));
        tick();

        run(3'd2, 1'b0, fill(5, 8'h64), fill(5, 8'h64), 9, 1'b0, "wrap2");
        check("wrap2 c", c, fill(2, 8'h20));
        check("wrap2 ovf", BW'(ovf), BW'(1));
        tick();
        check("hold c", c, fill(2, 8'h20));
        check("hold ovf", BW'(ovf), BW'(1));

        run(3'd2, 1'b1, fill(5, 8'h64), fill(5, 8'h9C), 9, 1'b0, "negsat2");
        check("negsat2 c", c, fill(2, 8'h80));
        check("negsat2 ovf", BW'(ovf), BW'(1));
        tick();

        run(3'd1, 1'b0, ident(), seq(5), 2, 1'b0, "dim1");
        check("dim1 c", c, seq(1));
        check("dim1 ovf", BW'(ovf), '0);
        tick();

        run(3'd0, 1'b0, ident(), seq(5), 126, 1'b1, "dim0_pulse");
        check("dim0_pulse c", c, seq(5));
        for (int n = 0; n < 4; n++) begin
            tick();
            check("no_extra_done", BW'(done), '0);
            check("no_extra_busy", BW'(busy), '0);
        end

        // start held high across two operations
        dim = 3'd2; sat_en = 1'b0; a = ident(); b = seq(5); start = 1'b1;
        tick();
        wait_done(9, 1'b1, "held1");
        start = 1'b1;
        check("held1 c", c, seq(2));
        tick();
        check("held idle busy", BW'(busy), '0);
        check("held idle done", BW'(done), '0);
        tick();
        check("held2 busy", BW'(busy), BW'(1));
        start = 1'b0;
        wait_done(9, 1'b0, "held2");
        check("held2 c", c, seq(2));
        tick();

        // asynchronous reset in the middle of an overflowing operation
        dim = 3'd5; sat_en = 1'b1; a = fill(5, 8'h64); b = fill(5, 8'h64); start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        check("pre_rst ovf", BW'(ovf), BW'(1));
        check("pre_rst c_nonzero", BW'(|c), BW'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst c", c, '0);
        check("rst busy", BW'(busy), '0);
        check("rst done", BW'(done), '0);
        check("rst ovf", BW'(ovf), '0);
        #3 rst_n = 1'b1;
        begin
            int seen = 0;
            for (int n = 0; n < 130; n++) begin
                tick();
                seen += int'(done) + int'(busy);
            end
            check("post_rst idle", BW'(seen), '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
